// File: rtl/or_sticky_n.sv
// or_sticky_n: registered N-input OR with a per-input mask and per-input
// sticky capture flags (write-1-to-clear). It also produces a one-cycle pulse
// when the OR result rises, and counts those pulses in a saturating counter.
//
// Optional feature: define OR_SYNC_EN to pass every A bit through a 2-flop
// synchroniser before masking. A->Z0/S latency is then 3 CK instead of 1.
// M, CLR and CNT_CLR are always sampled directly.
module or_sticky_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             CK,
  input  logic             RN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] CLR,
  input  logic             CNT_CLR,
  output logic             Z0,
  output logic             ZR,
  output logic [WIDTH-1:0] S,
  output logic [CNT_W-1:0] CNT
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] e;
  logic             any;
  logic             rise;

`ifdef OR_SYNC_EN
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] a_p1;

  // Two-flop synchroniser on every A bit; it clears with the rest of the block.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      a_p0 <= '0;
      a_p1 <= '0;
    end else begin
      a_p0 <= A;
      a_p1 <= a_p0;
    end
  end

  assign a_in = a_p1;
`else
  assign a_in = A;
`endif

  // Masked inputs take no part in the OR or in the sticky capture.
  assign e    = a_in & ~M;
  assign any  = |e;
  // Z0 holds the previous OR result, so this is a 0->1 transition of the OR.
  assign rise = any & ~Z0;

  // Increment that stops at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return v;
    else              return v + CNT_W'(1);
  endfunction

  // OR result, rising-edge pulse, sticky flags and event counter.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      Z0  <= 1'b0;
      ZR  <= 1'b0;
      S   <= '0;
      CNT <= '0;
    end else begin
      Z0 <= any;
      ZR <= rise;
      // Set dominates: a bit that is cleared and set in the same cycle stays set.
      S  <= e | (S & ~CLR);
      // A clear in the same cycle as a rising edge wins, and that edge is not counted.
      if (CNT_CLR)   CNT <= '0;
      else if (rise) CNT <= sat_inc(CNT);
    end
  end

endmodule
